pe_network_interface: RTL

- Network interface (NIC) between a processing element (PE) and the PE port of a mesh router.
- Upstream of the router's PE input: it injects 64-bit packets into the router through the send/ready handshake.
- Downstream of the router's PE output: it absorbs delivered packets and buffers them for the PE.
- The PE accesses the block through a 4-word register interface. Injection is gated by the router polarity, so a packet is only sent in its virtual-channel phase.

---
 rtl/pe_network_interface.sv | 110 +++++++++++
 1 files changed

// File: rtl/pe_network_interface.sv
// PE-side network interface: a register-mapped TX FIFO injects packets into the router
// PE port (gated by virtual-channel polarity); an RX FIFO buffers delivered packets.
module pe_network_interface #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  net_polarity,
  output logic                  net_si,
  input  logic                  net_ri,
  output logic [DATA_WIDTH-1:0] net_di,
  input  logic                  net_so,
  output logic                  net_ro,
  input  logic [DATA_WIDTH-1:0] net_do
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] tx_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem_q [DEPTH];
  logic [PTR_W-1:0]      tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PTR_W-1:0]      rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] d_out_q, d_out_d;

  logic                  tx_empty, tx_full, rx_empty, rx_full;
  logic                  tx_push, tx_pop, rx_push, rx_pop, pe_wr, rd_en;
  logic [DATA_WIDTH-1:0] tx_head, rx_head;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == CNT_W'(DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CNT_W'(DEPTH));
  assign tx_head  = tx_mem_q[tx_rd_q];
  assign rx_head  = rx_mem_q[rx_rd_q];

  // Bit 63 of the head packet selects its virtual channel; send only in the matching phase.
  assign net_si  = !tx_empty && (tx_head[DATA_WIDTH-1] == net_polarity);
  assign net_di  = tx_head;
  assign net_ro  = !rx_full;
  assign d_out   = d_out_q;

  assign pe_wr   = nicEn && nicWrEn && (addr == 2'd2);
  assign rd_en   = nicEn && !nicWrEn;
  assign tx_push = pe_wr && !tx_full;
  assign tx_pop  = net_si && net_ri;
  assign rx_push = net_so && !rx_full;
  assign rx_pop  = rd_en && (addr == 2'd0) && !rx_empty;

  // Next-state for pointers, counts, sticky overflow and the read register.
  always_comb begin
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    tx_cnt_d = tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
    rx_cnt_d = rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
    ovf_d    = ovf_q | (pe_wr & tx_full);
    d_out_d  = d_out_q;
    if (tx_push) tx_wr_d = tx_wr_q + PTR_W'(1);
    if (tx_pop)  tx_rd_d = tx_rd_q + PTR_W'(1);
    if (rx_push) rx_wr_d = rx_wr_q + PTR_W'(1);
    if (rx_pop)  rx_rd_d = rx_rd_q + PTR_W'(1);
    if (rd_en) begin
      case (addr)
        2'd0:    d_out_d = rx_empty ? '0 : rx_head;
        2'd1:    d_out_d = DATA_WIDTH'(!rx_empty);
        2'd3:    d_out_d = DATA_WIDTH'({ovf_q, tx_full});
        default: d_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      ovf_q    <= 1'b0;
      d_out_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
    end else begin
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      ovf_q    <= ovf_d;
      d_out_q  <= d_out_d;
      if (tx_push) tx_mem_q[tx_wr_q] <= d_in;
      if (rx_push) rx_mem_q[rx_wr_q] <= net_do;
    end
  end

endmodule
